uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit-side scheduler that sits between byte producers (CPU store path, debug print logic) and the UART transmitter. Buffers bytes in a DEPTH-entry FIFO with a valid/ready push port, launches one byte at a time into the transmitter with a single-cycle write strobe, and tracks the transmitter's busy flag to sequence back-to-back frames. Provides occupancy, idle and sticky error status for software polling.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- LAUNCH_TIMEOUT, 4, max cycles in WAIT_BUSY for tx_busy to rise; ≥ 1
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a byte
- in_data  input  8  producer byte
- in_ready  output  1  FIFO can accept; push occurs when in_valid & in_ready
- flush  input  1  synchronous FIFO clear
- err_clr  input  1  clears err
- tx_write_en  output  1  one-cycle launch strobe to transmitter
- tx_data  output  8  byte to transmitter, stable from launch cycle until next launch
- tx_busy  input  1  transmitter busy flag
- fifo_count  output  $clog2(DEPTH+1)  bytes queued (excludes in-flight byte)
- idle  output  1  FIFO empty and FSM in IDLE
- err  output  1  sticky launch-timeout flag

## Operation
- FIFO: circular buffer, rd/wr pointers $clog2(DEPTH) bits, wrap naturally; count tracked separately.
- in_ready = (fifo_count != DEPTH); combinational from count only, never from pop. Full FIFO with same-cycle pop does not accept.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE -> LAUNCH when fifo_count > 0 and tx_busy == 0; on this edge head byte loaded into tx_data register and popped.
  - LAUNCH: tx_write_en = 1; always -> WAIT_BUSY next cycle.
  - WAIT_BUSY: tx_busy == 1 -> WAIT_DONE; else timer increments; timer reaching LAUNCH_TIMEOUT -> IDLE, err set, byte dropped.
  - WAIT_DONE: tx_busy == 0 -> LAUNCH if fifo_count > 0 (pop + load on this edge), else IDLE.
- tx_write_en is decoded from the state register only (state == LAUNCH), no combinational path from inputs.
- flush: pointers and count cleared; in-flight byte (LAUNCH/WAIT_*) completes normally. flush with simultaneous push: flush wins, byte discarded, in_ready still reflects pre-flush count that cycle. flush wins over a same-cycle pop too (FSM then stays/returns per count = 0).
- err: set on timeout; err_clr clears; set wins over simultaneous clear.
- idle = (state == IDLE) & (fifo_count == 0).

## Timing
- Reset (rst_n low, async): state IDLE, pointers/count 0, tx_write_en 0, tx_data 8'h00, err 0, timer 0; in_ready 1, idle 1, fifo_count 0 after reset.
- Reset mid-frame: all of the above immediately; queued bytes lost; no strobe issued until a new push.
- Latency: push at cycle N into empty FIFO with tx_busy low -> count 1 at N+1, state LAUNCH at N+2 (tx_write_en high cycle N+2), tx_data valid from N+2.
- Transmitter raises tx_busy the cycle after the strobe; WAIT_BUSY normally lasts 1 cycle.
- Back-to-back: tx_busy falls at cycle M -> next tx_write_en at M+1. No strobe ever issued while tx_busy is high.
- Exactly one tx_write_en pulse per popped byte; strobe width always 1 cycle.

## Test plan
- Single byte: push 8'hA5 into empty FIFO, transmitter model 10-cycle busy -> one strobe at push+2 with tx_data 8'hA5, idle returns 1 after busy falls.
- Burst: push 16 bytes 8'h00..8'h0F in consecutive cycles -> in_ready stays high until count 16, bytes strobed in order, each strobe exactly one cycle after previous busy fall.
- Full backpressure: push 17 bytes with tx_busy held high -> 17th not accepted (in_ready 0), count 16; release busy -> 16 strobes, 17th accepted once count 15.
- Flush: queue 5 bytes while byte 1 in flight, assert flush -> count 0, byte 1 completes, no further strobes.
- Timeout: transmitter model never raises busy -> err 1 after LAUNCH_TIMEOUT cycles, FSM IDLE, next byte launched; err_clr -> err 0.
- Async reset during WAIT_DONE with 3 queued -> tx_write_en 0, count 0, idle 1 without clock edge.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: byte FIFO in front of a UART transmitter. Launches one byte per
// single-cycle strobe, sequenced on tx_busy, with a launch timeout and sticky error.
module uart_tx_sched #(
  parameter int DEPTH          = 16,
  parameter int LAUNCH_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic                       tx_write_en,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       idle,
  output logic                       err,
  output logic [1:0]                 dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);

  // Push handshake: a byte is taken on a rising edge where in_valid && in_ready and
  // flush is low; in_ready depends on the stored count only, never on a same-cycle pop.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q;
  logic          err_q;
  logic          push, pop, set_err, can_launch;

  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid & in_ready & ~flush;
  // A flush in the same cycle suppresses the pop, so the FSM sees an empty FIFO.
  assign can_launch = (count_q != '0) & ~flush;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    pop     = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (can_launch && !tx_busy) begin
          state_d = S_LAUNCH;
          pop     = 1'b1;
        end
      end
      S_LAUNCH: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(LAUNCH_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          set_err = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (can_launch) begin
            state_d = S_LAUNCH;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
      if (pop) tx_data_q <= mem[rd_ptr_q];
      if (set_err)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign tx_write_en = (state_q == S_LAUNCH);
  assign tx_data     = tx_data_q;
  assign fifo_count  = count_q;
  assign idle        = (state_q == S_IDLE) && (count_q == '0);
  assign err         = err_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus a random phase, scored against a
// byte-queue model of the FIFO and a simple busy-flag transmitter model.
module tb_uart_tx_sched;
  localparam int DEPTH          = 16;
  localparam int LAUNCH_TIMEOUT = 4;
  localparam int CW             = $clog2(DEPTH + 1);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, flush = 1'b0, err_clr = 1'b0, tx_busy = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, tx_write_en, idle, err;
  logic [7:0]    tx_data;
  logic [CW-1:0] fifo_count;
  logic [1:0]    dbg_state;

  uart_tx_sched #(.DEPTH(DEPTH), .LAUNCH_TIMEOUT(LAUNCH_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .err_clr(err_clr),
    .tx_write_en(tx_write_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .idle(idle), .err(err), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and transmitter model state
  logic [7:0] exp_q[$];
  int  errors = 0, checks = 0, cyc = 0, strobes = 0, last_strobe_cyc = -1;
  int  tx_mode = 0;  // 0: busy for busy_len cycles, 1: never busy, 2: busy held by main
  int  busy_len = 4, busy_left = 0, gap_cyc = 0;
  bit  rand_len = 1'b0, prev_we = 1'b0, gap_due = 1'b0, last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the driven inputs, then sample at the negedge.
  task automatic tick();
    bit exp_rdy, do_push, do_flush;
    logic [7:0] d, e;
    exp_rdy  = (exp_q.size() != DEPTH);
    if (rst_n) chk("in_ready", in_ready, exp_rdy);
    do_push  = rst_n && in_valid && exp_rdy && !flush;
    do_flush = rst_n && flush;
    d = in_data;
    @(negedge clk);
    cyc++;
    last_acc = do_push;
    if (do_flush) exp_q.delete();
    else if (do_push) exp_q.push_back(d);
    if (tx_write_en === 1'b1) begin
      strobes++;
      last_strobe_cyc = cyc;
      chk("strobe_while_busy", tx_busy, 0);
      chk("strobe_width", prev_we, 0);
      if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tx_data", tx_data, e);
      end
    end
    if (gap_due && cyc == gap_cyc) begin
      chk("b2b_gap", tx_write_en, 1);
      gap_due = 1'b0;
    end
    prev_we = tx_write_en;
    chk("fifo_count", fifo_count, exp_q.size());
    if (tx_mode == 0) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_busy = 1'b0;
          if (exp_q.size() > 0) begin
            gap_due = 1'b1;
            gap_cyc = cyc + 1;
          end
        end
      end
      if (tx_write_en === 1'b1) begin
        tx_busy   = 1'b1;
        busy_left = rand_len ? int'($urandom_range(2, 7)) : busy_len;
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && tx_busy == 1'b0 && idle === 1'b1) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_in_bound", done, 1);
  endtask

  initial begin
    int s0, push_cyc, lcyc;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_write_en", tx_write_en, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // single byte, 10-cycle busy
    busy_len = 10;
    push_byte(8'hA5);
    push_cyc = cyc;
    tick();
    chk("single_latency", last_strobe_cyc, push_cyc + 1);
    repeat (10) tick();
    chk("single_idle_during", idle, 0);
    tick();
    chk("single_idle_after", idle, 1);
    chk("single_tx_data_hold", tx_data, 8'hA5);

    // burst of 16 consecutive bytes
    busy_len = 3;
    s0 = strobes;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_drain(300);
    chk("burst_strobes", strobes - s0, 16);

    // full backpressure with busy held high
    tx_mode = 2;
    tx_busy = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    in_valid = 1'b1;
    in_data  = 8'h50;
    tick();
    chk("full_count", fifo_count, 16);
    chk("full_ready", in_ready, 0);
    tick();
    chk("full_no_launch", strobes - s0, 0);
    tx_mode  = 0;
    busy_len = 2;
    tx_busy  = 1'b0;
    for (int i = 0; i < 40 && !last_acc; i++) tick();
    in_valid = 1'b0;
    wait_drain(300);
    chk("full_strobes", strobes - s0, 17);

    // flush while byte 1 in flight
    busy_len = 10;
    push_byte(8'h77);
    tick();
    for (int i = 0; i < 5; i++) push_byte(8'h80 + 8'(i));
    chk("flush_pre_count", fifo_count, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", fifo_count, 0);
    s0 = strobes;
    repeat (15) tick();
    chk("flush_no_strobe", strobes - s0, 0);
    chk("flush_idle", idle, 1);

    // launch timeout: transmitter never raises busy
    tx_mode = 1;
    push_byte(8'h3C);
    tick();
    lcyc = cyc;
    chk("to_launch", last_strobe_cyc, lcyc);
    repeat (LAUNCH_TIMEOUT) tick();
    chk("to_err_early", err, 0);
    tick();
    chk("to_err_set", err, 1);
    chk("to_idle", idle, 1);
    tx_mode  = 0;
    busy_len = 3;
    push_byte(8'h3D);
    tick();
    chk("to_relaunch", last_strobe_cyc, cyc);
    wait_drain(50);
    chk("to_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", err, 0);

    // async reset during WAIT_DONE with 3 queued
    busy_len = 12;
    for (int i = 0; i < 4; i++) push_byte(8'h91 + 8'(i));
    tick();
    chk("rstmid_count", fifo_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_write_en", tx_write_en, 0);
    chk("rstmid_count0", fifo_count, 0);
    chk("rstmid_idle", idle, 1);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_tx_data", tx_data, 8'h00);
    exp_q.delete();
    tx_busy   = 1'b0;
    busy_left = 0;
    gap_due   = 1'b0;
    prev_we   = 1'b0;
    tick();
    rst_n = 1'b1;
    s0 = strobes;
    repeat (10) tick();
    chk("rstmid_no_strobe", strobes - s0, 0);

    // random traffic with random busy lengths
    rand_len = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_drain(400);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
